// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: source select enum, default widths, buffered result entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package wb_pkg;

    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_MEM
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with full/empty/count; head is visible on dout.
// Zero-cycle read of the head; push ignored when full, pop ignored when empty (no full pass-through).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           din,
    input  logic             pop,
    output entry_t           dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU results and FIFO-buffered memory results into one registered RF write per cycle, one-cycle latency.
// mem_ready = FIFO not full; alu_ready drops only when WB_STARVE_GUARD_EN forces a FIFO drain.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           fifo_din;
    entry_t           fifo_dout;
    entry_t           win;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             force_drain;
    logic             win_wr;
    wb_src_e          src;

    assign fifo_din  = '{addr: mem_addr, data: mem_data};
    assign fifo_push = mem_valid && !fifo_full;
    assign fifo_pop  = (src == WB_SRC_MEM);
    assign mem_ready = !fifo_full;
    assign alu_ready = !force_drain;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int                SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]   LIMIT = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt;

    // Counts consecutive ALU wins that left a buffered memory result waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if ((src == WB_SRC_ALU) && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_drain = (starve_cnt == LIMIT);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_drain = 1'b0;
`endif

    always_comb begin
        src = WB_SRC_NONE;
        if (!force_drain && alu_valid) begin
            src = WB_SRC_ALU;
        end else if (!fifo_empty) begin
            src = WB_SRC_MEM;
        end
    end

    assign win    = (src == WB_SRC_MEM) ? fifo_dout : '{addr: alu_addr, data: alu_data};
    // Address 0 is not backed by the register file: consume the entry, suppress the write.
    assign win_wr = (src != WB_SRC_NONE) && (win.addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= win_wr;
            if (win_wr) begin
                rf_waddr <= win.addr;
                rf_wdata <= win.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_empty == (fifo_count == '0));
        end
    end

endmodule
